// File: rtl/past_history_ctrl.sv
// Gated past-value history shared by two requesters through a round-robin arbiter.
// Lookups use pre-edge history; the response is registered at the grant edge.
module past_history_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [IDXW-1:0]  req0_idx,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IDXW-1:0]  req1_idx,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_hit
);

    localparam logic [IDXW:0] COUNT_FULL = (IDXW+1)'(DEPTH);

    logic [WIDTH-1:0] hist [DEPTH];
    logic [IDXW-1:0]  wptr;
    logic [IDXW:0]    count;
    logic             last;

    logic             grant0;
    logic             grant1;
    logic [IDXW-1:0]  sel_idx;
    logic [IDXW-1:0]  rd_addr;
    logic             sel_hit;

    // last holds the previously served requester; a tie goes to the other one.
    always_comb begin
        grant0  = req0_valid && (!req1_valid || last);
        grant1  = req1_valid && (!req0_valid || !last);
        sel_idx = grant1 ? req1_idx : req0_idx;
        rd_addr = wptr - IDXW'(1) - sel_idx;
        sel_hit = {1'b0, sel_idx} < count;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (clr) begin
            wptr  <= '0;
            count <= '0;
        end else if (en) begin
            hist[wptr] <= din;
            wptr       <= wptr + IDXW'(1);
            if (count != COUNT_FULL) begin
                count <= count + (IDXW+1)'(1);
            end
        end
    end

    // Non-valid cycles keep id/data/hit so the last response stays observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
            last      <= 1'b1;
        end else if (grant0 || grant1) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant1;
            rsp_data  <= sel_hit ? hist[rd_addr] : '0;
            rsp_hit   <= sel_hit;
            last      <= grant1;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_past_history_ctrl.sv
// Bench for past_history_ctrl: directed scenarios plus random traffic against a
// queue-based model of enabled samples and a round-robin grant model.
module tb_past_history_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] din;
    logic             clr;
    logic             req0_valid;
    logic [IDXW-1:0]  req0_idx;
    logic             req0_ready;
    logic             req1_valid;
    logic [IDXW-1:0]  req1_idx;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_hit;

    past_history_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
        .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_hit(rsp_hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: enabled samples since last clear/reset, newest at the back.
    int               hq[$];
    bit               m_last;
    logic             e_valid, e_id, e_hit;
    logic [WIDTH-1:0] e_data;
    logic             e_r0, e_r1, o_r0, o_r1;

    task automatic model_reset();
        hq.delete();
        m_last  = 1'b1;
        e_valid = 1'b0; e_id = 1'b0; e_hit = 1'b0; e_data = '0;
    endtask

    // Called at posedge+1 after inputs are driven; returns at the next posedge+1.
    task automatic tick();
        int k, n;
        #1;
        o_r0 = req0_ready;
        o_r1 = req1_ready;
        e_r0 = req0_valid && (!req1_valid || m_last);
        e_r1 = req1_valid && !e_r0;
        if (e_r0 || e_r1) begin
            k = e_r1 ? int'(req1_idx) : int'(req0_idx);
            n = hq.size();
            e_valid = 1'b1;
            e_id    = e_r1;
            e_hit   = (k < n);
            e_data  = (k < n) ? WIDTH'(hq[n-1-k]) : '0;
            m_last  = e_r1;
        end else begin
            e_valid = 1'b0;
        end
        if (clr) hq.delete();
        else if (en) begin
            hq.push_back(int'(din));
            if (hq.size() > DEPTH) void'(hq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v0, input int i0, input logic v1, input int i1);
        req0_valid = v0; req0_idx = IDXW'(i0);
        req1_valid = v1; req1_idx = IDXW'(i1);
    endtask

    task automatic test_reset();
        total++;
        if ({rsp_valid, rsp_id, rsp_hit, rsp_data} !== 7'b0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b id=%b hit=%b data=%0d want all 0",
                     rsp_valid, rsp_id, rsp_hit, rsp_data);
        end
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
    endtask

    task automatic test_arbitration();
        set_req(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({o_r0, o_r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL arb_tie_grant[%0d]: got %b%b want %0s", i, o_r0, o_r1,
                         (i % 2 == 0) ? "10" : "01");
            end
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2)) begin
                bad++;
                $display("FAIL arb_rsp_id[%0d]: got v=%b id=%b want v=1 id=%0d", i, rsp_valid, rsp_id, i % 2);
            end
        end
        set_req(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({o_r0, o_r1, rsp_valid, rsp_id} !== 4'b0111) begin
                bad++;
                $display("FAIL arb_single[%0d]: got r=%b%b v=%b id=%b want r=01 v=1 id=1",
                         i, o_r0, o_r1, rsp_valid, rsp_id);
            end
        end
        set_req(0, 0, 0, 0);
        tick();
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b1) begin
            bad++;
            $display("FAIL arb_idle: got v=%b id=%b want v=0 id=1 (held)", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_fill();
        int vals[3] = '{3, 7, 9};
        int idxs[3] = '{0, 2, 3};
        logic [6:0] want[3] = '{{1'b1, 1'b0, 1'b1, 4'd9}, {1'b1, 1'b0, 1'b1, 4'd3},
                                {1'b1, 1'b0, 1'b0, 4'd0}};
        foreach (vals[i]) begin
            en = 1; din = WIDTH'(vals[i]);
            tick();
        end
        en = 0;
        foreach (idxs[i]) begin
            set_req(1, idxs[i], 0, 0);
            tick();
            total++;
            if ({rsp_valid, rsp_id, rsp_hit, rsp_data} !== want[i]) begin
                bad++;
                $display("FAIL fill_idx%0d: got v=%b id=%b hit=%b data=%0d want %b",
                         idxs[i], rsp_valid, rsp_id, rsp_hit, rsp_data, want[i]);
            end
        end
        set_req(0, 0, 0, 0);
    endtask

    task automatic test_gating();
        en = 1; din = 5; tick();
        en = 0;
        for (int i = 0; i < 4; i++) begin
            din = WIDTH'($urandom_range(0, 15));
            tick();
        end
        en = 1; din = 6; tick();
        en = 0;
        for (int k = 0; k < 2; k++) begin
            set_req(1, k, 0, 0);
            tick();
            total++;
            if (rsp_hit !== 1'b1 || rsp_data !== ((k == 0) ? 4'd6 : 4'd5)) begin
                bad++;
                $display("FAIL gating_idx%0d: got hit=%b data=%0d want hit=1 data=%0d",
                         k, rsp_hit, rsp_data, (k == 0) ? 6 : 5);
            end
        end
        set_req(0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        clr = 1; tick(); clr = 0;
        en = 1;
        for (int v = 1; v <= 10; v++) begin
            din = WIDTH'(v);
            tick();
        end
        en = 0;
        for (int j = 0; j < 2; j++) begin
            set_req(0, 0, 1, (j == 0) ? 0 : 7);
            tick();
            total++;
            if (rsp_hit !== 1'b1 || rsp_data !== ((j == 0) ? 4'd10 : 4'd3)) begin
                bad++;
                $display("FAIL wrap_idx%0d: got hit=%b data=%0d want hit=1 data=%0d",
                         (j == 0) ? 0 : 7, rsp_hit, rsp_data, (j == 0) ? 10 : 3);
            end
        end
        set_req(0, 0, 0, 0);
    endtask

    task automatic test_same_edge();
        en = 1; din = 4; tick();
        din = 12; set_req(1, 0, 0, 0); tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'd4) begin
            bad++;
            $display("FAIL same_edge_old: got v=%b data=%0d want v=1 data=4", rsp_valid, rsp_data);
        end
        en = 0; tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'd12) begin
            bad++;
            $display("FAIL same_edge_new: got v=%b data=%0d want v=1 data=12", rsp_valid, rsp_data);
        end
        set_req(0, 0, 0, 0);
    endtask

    task automatic test_clear();
        en = 1; din = 8; tick();
        clr = 1; din = 2; set_req(1, 0, 0, 0); tick();
        total++;
        if (rsp_hit !== 1'b1 || rsp_data !== 4'd8) begin
            bad++;
            $display("FAIL clear_preclear_read: got hit=%b data=%0d want hit=1 data=8", rsp_hit, rsp_data);
        end
        clr = 0; en = 0; tick();
        total++;
        if ({rsp_valid, rsp_hit, rsp_data} !== 6'b100000) begin
            bad++;
            $display("FAIL clear_miss: got v=%b hit=%b data=%0d want v=1 hit=0 data=0",
                     rsp_valid, rsp_hit, rsp_data);
        end
        set_req(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int n_cyc = 300;
        for (int c = 0; c < n_cyc; c++) begin
            en  = ($urandom_range(0, 9) < 7);
            din = WIDTH'($urandom_range(0, 15));
            clr = ($urandom_range(0, 39) == 0);
            if (!(req0_valid && !e_r0) || c == 0) begin
                req0_valid = $urandom_range(0, 1);
                req0_idx   = IDXW'($urandom_range(0, DEPTH - 1));
            end
            if (!(req1_valid && !e_r1) || c == 0) begin
                req1_valid = $urandom_range(0, 1);
                req1_idx   = IDXW'($urandom_range(0, DEPTH - 1));
            end
            tick();
            total++;
            if ({o_r0, o_r1} !== {e_r0, e_r1}) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b%b want %b%b", c, o_r0, o_r1, e_r0, e_r1);
            end
            total++;
            if ({rsp_valid, rsp_id, rsp_hit, rsp_data} !== {e_valid, e_id, e_hit, e_data}) begin
                bad++;
                $display("FAIL rand_rsp[%0d]: got v=%b id=%b hit=%b data=%0d want v=%b id=%b hit=%b data=%0d",
                         c, rsp_valid, rsp_id, rsp_hit, rsp_data, e_valid, e_id, e_hit, e_data);
            end
        end
        en = 0; clr = 0; set_req(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        en = 1; din = 11; tick();
        en = 0; set_req(1, 0, 0, 0); tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'd11) begin
            bad++;
            $display("FAIL reset_mid_pre: got v=%b data=%0d want v=1 data=11", rsp_valid, rsp_data);
        end
        #1 rst_n = 0;
        #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_hit, rsp_data} !== 7'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got v=%b id=%b hit=%b data=%0d want all 0",
                     rsp_valid, rsp_id, rsp_hit, rsp_data);
        end
        set_req(0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        set_req(1, 0, 1, 0);
        tick();
        total++;
        if ({o_r0, o_r1, rsp_valid, rsp_id, rsp_hit} !== 5'b10100) begin
            bad++;
            $display("FAIL reset_mid_arb: got r=%b%b v=%b id=%b hit=%b want r=10 v=1 id=0 hit=0",
                     o_r0, o_r1, rsp_valid, rsp_id, rsp_hit);
        end
        set_req(0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst_n = 0; en = 0; din = '0; clr = 0;
        set_req(0, 0, 0, 0);
        model_reset();
        e_r0 = 0; e_r1 = 0;
        #12 rst_n = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_arbitration();
        test_fill();
        test_gating();
        test_wrap();
        test_same_edge();
        test_clear();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/past_history_ctrl.md
# past_history_ctrl

Hardware equivalent of a gated `$past()` lookup, shared between two requesters. The block captures `din` on every clock edge where `en` is high into a DEPTH-entry circular history. Two requesters ask for the value k enabled-samples back through valid/ready ports. A round-robin arbiter serves one request per cycle and returns a registered response. It sits beside the SVA/checker datapath, where hardware monitors need past values without duplicating delay lines.

## Interface
- `WIDTH`, 4, sample width in bits
- `DEPTH`, 8, history depth; power of two, ≥2
- `IDXW`, $clog2(DEPTH), request index width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  capture enable (gating)
- `din`  in  WIDTH  sample to capture
- `clr`  in  1  synchronous history clear
- `req0_valid`  in  1  requester 0 request
- `req0_idx`  in  IDXW  requester 0 lookback (0 = most recent capture)
- `req0_ready`  out  1  requester 0 granted this cycle
- `req1_valid`  in  1  requester 1 request
- `req1_idx`  in  IDXW  requester 1 lookback
- `req1_ready`  out  1  requester 1 granted this cycle
- `rsp_valid`  out  1  response strobe, one cycle
- `rsp_id`  out  1  requester served
- `rsp_data`  out  WIDTH  looked-up sample; 0 on miss
- `rsp_hit`  out  1  requested entry exists

## Operation
- **Storage:** DEPTH×WIDTH array `hist`, write pointer `wptr` (IDXW bits), fill counter `count` (0..DEPTH, IDXW+1 bits).
- **Capture:** on an edge with `en`=1 and `clr`=0:
  - `hist[wptr]` ← `din`
  - `wptr` ← `wptr`+1, wrapping DEPTH-1 → 0
  - `count` ← min(`count`+1, DEPTH)
- **Clear:** `clr`=1 sets `wptr` and `count` to 0. `clr` beats `en`, so a capture in the same cycle is dropped. Array contents are left as they are; they are unreachable because `count`=0.
- **Lookup semantics:** reads use the pre-edge state (sampled-value semantics).
  - `idx` k returns `hist[(wptr-1-k) mod DEPTH]`.
  - This equals `$past(din, k+1, en)` counted in enabled samples.
  - Hit when k < `count`. On a miss, `rsp_data`=0 and `rsp_hit`=0.
- **Arbiter:** round-robin with one-bit register `last`.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester ≠ `last`.
  - `last` updates only on a grant.
  - `reqN_ready` is combinational from the valids and `last`; it is high only for the granted requester.
- **Handshake:**
  - A request transfers when `reqN_valid` && `reqN_ready`.
  - A requester that is not granted holds `valid` and `idx` stable until granted.
  - Responses have no backpressure.
- **Response:** registered at the grant edge. `rsp_valid`=1 for exactly one cycle, with `rsp_id`, `rsp_data`, `rsp_hit`. The next cycle returns `rsp_valid`=0 unless another grant occurs; the other fields hold.

## Timing
- **Reset** (async assert, sync-safe deassert):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_hit`=0
  - `wptr`=0, `count`=0, `last`=1, so requester 0 wins the first tie
  - `hist` cleared to 0
- **Latency:**
  - Grant is in the request cycle.
  - Response appears the cycle after the grant edge (1-cycle latency).
  - Throughput is one response per cycle.
- **Capture and read on the same edge:** the read returns the old history; the new sample is visible at `idx` 0 from the next edge.
- **`clr` and read on the same edge:** the read sees the pre-clear history.
- **Wrap:** after DEPTH+n captures, `idx` DEPTH-1 returns capture number n+1 (1-based); the oldest entries are overwritten.
- **`count` saturation:** `count` stays at DEPTH; `idx` is always < DEPTH, so every lookup hits once the buffer is full.
- **Reset mid-operation:** an outstanding response is dropped, and the arbiter returns to `last`=1.

## Test plan
- **Fill:** after reset, capture `din`=3,7,9 with `en`=1. Then req0 `idx`=0 → `rsp_data`=9, `rsp_hit`=1, `rsp_id`=0. Then req0 `idx`=2 → `rsp_data`=3. Then req0 `idx`=3 → `rsp_hit`=0, `rsp_data`=0.
- **Gating:** capture 5 with `en`=1, hold `en`=0 for 4 cycles while `din` changes, then capture 6. `idx`=0 → 6 and `idx`=1 → 5; the gated cycles never appear.
- **Wrap:** capture `din`=1..10 with DEPTH=8. `idx`=0 → 10 and `idx`=7 → 3, both with `rsp_hit`=1.
- **Arbitration:** both requesters valid for 4 cycles. Grants must go 0,1,0,1, and `rsp_id` follows one cycle later. With a single requester valid, it is granted every cycle.
- **Same-edge corner:** `en`=1 with `din`=12 on the same edge as a req0 `idx`=0 grant, where the previous capture was 4 → response 4. The next `idx`=0 lookup → 12.
- **Clear/reset:** `clr`=1 while `en`=1 → a following `idx`=0 misses. Asserting `rst_n`=0 while a grant is pending → `rsp_valid`=0 immediately, and all outputs return to 0.
